bloom_distinct_counter: RTL and testbench
=========================================

# bloom_distinct_counter

Parametrised Bloom-filter distinct-item counter: accepts a stream of DATA_W-bit items over a valid/ready handshake, tests each against a FILTER_BITS-bit filter using NUM_HASH hash indices, and increments a COUNT_W-bit count only for items not already represented. It supersedes the fixed 8-bit/16-bit single-index counter with multi-hash indexing, a two-stage pipeline, a per-item result stream, and a drained synchronous clear. It sits between a data-producing peripheral and the wishbone register block, which reads `count` and `busy` and pulses `clear`.

## Interface
- DATA_W, 8: input item width (1..32).
- IDX_W, 8: filter index width; FILTER_BITS = 2**IDX_W (4..10).
- NUM_HASH, 2: hash functions per item (1..4).
- COUNT_W, 16: distinct-count width (2..32).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  item present on in_data.
- in_ready  out  1  block can accept an item this cycle.
- in_data  in  DATA_W  item.
- clear  in  1  single-cycle request to empty filter and zero count.
- out_valid  out  1  one-cycle pulse: result for one accepted item.
- out_new  out  1  qualified by out_valid; 1 = item counted as new.
- count  out  COUNT_W  current distinct count.
- busy  out  1  clear sequence in progress.
- sat  out  1  count has saturated (see Configuration).

## Operation
- Accept when in_valid && in_ready on a rising edge; in_ready = (state == RUN) && !clear (combinational).
- Hashing: fold(x) = XOR of consecutive IDX_W-bit chunks of x zero-extended to a multiple of IDX_W. h_k = fold(rotl(in_data, k)) XOR k[IDX_W-1:0], k = 0..NUM_HASH-1; rotl is rotate-left within DATA_W.
- Stage 1 (S1): registers h_0..h_{NUM_HASH-1} and a valid bit.
- Stage 2 (S2): hit = AND of filter[h_k] for all k. If !hit: set all filter[h_k], increment count. Registers out_valid=1, out_new=!hit.
- S2 reads filter as updated by the previous item; back-to-back identical items: second gives out_new=0. No forwarding needed.
- Duplicate indices (h_i == h_j) are legal; bit set once.
- FSM: RUN -> DRAIN on clear while in RUN; DRAIN -> CLEAR when S1 and S2 valid bits both 0; CLEAR -> RUN after exactly one cycle, which zeroes filter, count and sat. busy = (state != RUN).
- clear during DRAIN/CLEAR ignored. clear with in_valid in same cycle: clear wins, item not accepted.
- Items in flight at clear complete normally (count/out_valid) before the zeroing.
- No output backpressure; out_valid is a pulse with no ready.

## Timing
- Reset values: in_ready 1 (after reset deasserts), out_valid 0, out_new 0, count 0, busy 0, sat 0, filter all 0, state RUN.
- Latency: item accepted at edge N -> out_valid/out_new/count update visible after edge N+2.
- Throughput: one item per cycle in RUN.
- Clear: request at edge N with pipeline empty -> DRAIN after N, CLEAR after N+1, zeroed count and RUN after N+2. Each in-flight item adds at most one DRAIN cycle (max 2).
- Reset mid-operation: immediate asynchronous return to reset values; in-flight items dropped, no out_valid.

## Configuration
- BLOOM_COUNT_SAT_EN defined: count stops at 2**COUNT_W-1; further new items still set filter bits and give out_new=1 but do not change count; sat goes 1 on the increment reaching max, cleared only by clear or reset.
- Not defined: count wraps modulo 2**COUNT_W; sat tied 0.

## Test plan
- Defaults: reset, feed 0x00,0x01,0x02 back-to-back -> out_new 1,1,1 at edges N+2..N+4, count=3.
- Repeat 0x01 twice back-to-back -> both out_new=0, count unchanged at 3.
- Pulse clear with items in flight -> in-flight results emitted, busy high 2-4 cycles, count=0 then 0x01 again -> out_new=1.
- clear and in_valid same cycle -> in_ready=0, item not accepted, no out_valid for it.
- COUNT_W=2, BLOOM_COUNT_SAT_EN on, 5 distinct non-colliding items -> count 3, sat=1; macro off -> count wraps to 1, sat=0.
- Assert reset mid-stream -> all outputs at reset values next cycle, no out_valid for pending items.

Source files
------------

// File: rtl/bloom_distinct_counter.sv
// Bloom-filter distinct-item counter: multi-hash filter lookup, two-stage pipeline,
// per-item result pulse and drained clear. Optional saturation via BLOOM_COUNT_SAT_EN.
//
// state | meaning
// RUN   | accepting items, pipeline flowing
// DRAIN | clear requested, waiting for in-flight items to finish
// CLEAR | one cycle: zero filter, count and sat
module bloom_distinct_counter #(
    parameter int DATA_W   = 8,
    parameter int IDX_W    = 8,
    parameter int NUM_HASH = 2,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               clear,
    output logic               out_valid,
    output logic               out_new,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               sat
);

    localparam int FILTER_BITS = 2 ** IDX_W;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_HASH-1:0][IDX_W-1:0] h_in;
    logic [NUM_HASH-1:0][IDX_W-1:0] s1_h;
    logic [NUM_HASH-1:0][IDX_W-1:0] s2_h;
    logic                           s1_v;
    logic                           s2_v;
    logic                           accept;
    logic                           hit;
    logic                           is_new;
    logic [FILTER_BITS-1:0]         filter;
    logic [FILTER_BITS-1:0]         set_mask;

    // Rotate-left by k within DATA_W, fold into IDX_W-bit chunks, then salt with k.
    function automatic logic [IDX_W-1:0] hash_idx(input logic [DATA_W-1:0] d, input int k);
        logic [DATA_W-1:0] r;
        logic [IDX_W-1:0]  h;
        r = '0;
        h = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[(i + k) % DATA_W] = d[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            h[i % IDX_W] = h[i % IDX_W] ^ r[i];
        end
        h = h ^ IDX_W'(k);
        return h;
    endfunction

    assign in_ready = (state == RUN) && !clear;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != RUN);

    always_comb begin
        h_in = '0;
        for (int k = 0; k < NUM_HASH; k++) begin
            h_in[k] = hash_idx(in_data, k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v <= 1'b0;
            s1_h <= '0;
            s2_v <= 1'b0;
            s2_h <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_h <= h_in;
            end
            s2_v <= s1_v;
            s2_h <= s1_h;
        end
    end

    // Filter is read after the previous item's update, so no forwarding path is needed.
    always_comb begin
        hit      = 1'b1;
        set_mask = '0;
        for (int k = 0; k < NUM_HASH; k++) begin
            hit              = hit & filter[s2_h[k]];
            set_mask[s2_h[k]] = 1'b1;
        end
    end

    assign is_new = s2_v && !hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter <= '0;
        end else if (state == CLEAR) begin
            filter <= '0;
        end else if (is_new) begin
            filter <= filter | set_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_new   <= 1'b0;
        end else begin
            out_valid <= s2_v;
            out_new   <= is_new;
        end
    end

`ifdef BLOOM_COUNT_SAT_EN
    logic sat_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            sat_r <= 1'b0;
        end else if (state == CLEAR) begin
            count <= '0;
            sat_r <= 1'b0;
        end else if (is_new && (count != CNT_MAX)) begin
            count <= count + COUNT_W'(1);
            if (count == (CNT_MAX - COUNT_W'(1))) begin
                sat_r <= 1'b1;
            end
        end
    end

    assign sat = sat_r;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (state == CLEAR) begin
            count <= '0;
        end else if (is_new) begin
            count <= count + COUNT_W'(1);
        end
    end

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (clear) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_v && !s2_v) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_bloom_distinct_counter.sv
// Directed bench for bloom_distinct_counter: default instance plus a COUNT_W=2
// instance for wrap/saturation, expectations follow BLOOM_COUNT_SAT_EN.
module tb_bloom_distinct_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        s_valid;
    logic [7:0]  in_data;
    logic        clear;

    logic        in_ready, out_valid, out_new, busy, sat;
    logic [15:0] count;
    logic        s_in_ready, s_out_valid, s_out_new, s_busy, s_sat;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bloom_distinct_counter #(.DATA_W(8), .IDX_W(8), .NUM_HASH(2), .COUNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .out_valid(out_valid), .out_new(out_new),
        .count(count), .busy(busy), .sat(sat)
    );

    bloom_distinct_counter #(.DATA_W(8), .IDX_W(8), .NUM_HASH(2), .COUNT_W(2)) u_small (
        .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_in_ready),
        .in_data(in_data), .clear(clear), .out_valid(s_out_valid), .out_new(s_out_new),
        .count(s_count), .busy(s_busy), .sat(s_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        s_valid  = 1'b0;
        in_data  = 8'h00;
        clear    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_new", out_new, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat, 0);

        // three distinct items back-to-back
        in_valid = 1'b1; in_data = 8'h00; tick();
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        chk("seq0_valid", out_valid, 1);
        chk("seq0_new", out_new, 1);
        chk("seq0_count", count, 1);
        in_valid = 1'b0; tick();
        chk("seq1_new", out_new, 1);
        chk("seq1_count", count, 2);
        tick();
        chk("seq2_valid", out_valid, 1);
        chk("seq2_new", out_new, 1);
        chk("seq2_count", count, 3);
        tick();
        chk("seq_idle_valid", out_valid, 0);

        // repeated item twice back-to-back
        in_valid = 1'b1; in_data = 8'h01; tick();
        tick();
        in_valid = 1'b0; tick();
        chk("dup0_valid", out_valid, 1);
        chk("dup0_new", out_new, 0);
        chk("dup0_count", count, 3);
        tick();
        chk("dup1_valid", out_valid, 1);
        chk("dup1_new", out_new, 0);
        chk("dup1_count", count, 3);
        tick();
        chk("dup_idle_valid", out_valid, 0);

        // clear with two items in flight
        in_valid = 1'b1; in_data = 8'h05; tick();
        in_data = 8'h06; tick();
        in_valid = 1'b0; clear = 1'b1; #1;
        chk("clr_in_ready", in_ready, 0);
        tick();
        clear = 1'b0;
        chk("clr_e1_busy", busy, 1);
        chk("clr_e1_valid", out_valid, 1);
        chk("clr_e1_new", out_new, 1);
        chk("clr_e1_count", count, 4);
        tick();
        chk("clr_e2_busy", busy, 1);
        chk("clr_e2_valid", out_valid, 1);
        chk("clr_e2_count", count, 5);
        tick();
        chk("clr_e3_busy", busy, 1);
        chk("clr_e3_valid", out_valid, 0);
        chk("clr_e3_count", count, 5);
        tick();
        chk("clr_e4_busy", busy, 0);
        chk("clr_e4_count", count, 0);
        chk("clr_e4_ready", in_ready, 1);

        in_valid = 1'b1; in_data = 8'h01; tick();
        in_valid = 1'b0; tick();
        tick();
        chk("post_clr_valid", out_valid, 1);
        chk("post_clr_new", out_new, 1);
        chk("post_clr_count", count, 1);

        // reset with items in flight
        in_valid = 1'b1; in_data = 8'h33; tick();
        in_data = 8'h44; tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrst_count", count, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        tick();
        chk("mrst_hold_valid", out_valid, 0);
        reset = 1'b0;
        tick();
        chk("mrst_a_valid", out_valid, 0);
        tick();
        chk("mrst_b_valid", out_valid, 0);
        chk("mrst_b_count", count, 0);
        chk("mrst_b_ready", in_ready, 1);

        // clear and in_valid in the same cycle
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h77; #1;
        chk("cv_in_ready", in_ready, 0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("cv_e1_busy", busy, 1);
        chk("cv_e1_valid", out_valid, 0);
        tick();
        chk("cv_e2_busy", busy, 1);
        chk("cv_e2_valid", out_valid, 0);
        tick();
        chk("cv_e3_busy", busy, 0);
        chk("cv_e3_valid", out_valid, 0);
        chk("cv_e3_count", count, 0);

        // five distinct non-colliding items into the 2-bit counter
        s_valid = 1'b1;
        in_data = 8'h10; tick();
        in_data = 8'h20; tick();
        in_data = 8'h30; tick();
        in_data = 8'h40; tick();
        in_data = 8'h50; tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("sm_valid", s_out_valid, 1);
        chk("sm_new", s_out_new, 1);
        chk("big_untouched", count, 0);
`ifdef BLOOM_COUNT_SAT_EN
        chk("sm_count", s_count, 3);
        chk("sm_sat", s_sat, 1);
`else
        chk("sm_count", s_count, 1);
        chk("sm_sat", s_sat, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
